train_detector: RTL and testbench

TRAIN_DETECTOR -- requirements
Module: train_detector

---
 rtl/train_detector.sv | 142 ++++++++++++++
 tb/tb_train_detector.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/train_detector.sv
// rtl/train_detector.sv - two-sensor train detector: sync, debounce, occupancy FSM with timeout
module train_detector #(
  parameter logic [15:0] DEB_CYCLES     = 16'd50000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000000
) (
  input  logic clk,
  input  logic rst,
  input  logic sens_a,
  input  logic sens_b,
  output logic entry,
  output logic exit,
  output logic dir,
  output logic busy,
  output logic fault
);

  localparam logic [15:0] DEB_LAST = DEB_CYCLES - 16'd1;
  localparam logic [31:0] TMO_LAST = TIMEOUT_CYCLES - 32'd1;

  typedef enum logic [1:0] {IDLE, OCC, LEAVE, FAULT} state_t;

  // Bit 0 carries sensor A, bit 1 carries sensor B throughout.
  logic [1:0]        sync1_q, sync2_q;
  logic [1:0]        deb_d, deb_q;
  logic [1:0]        deb_dly_q;
  logic [1:0][15:0]  deb_cnt_d, deb_cnt_q;
  logic [1:0]        rise, fall;

  state_t      state_d, state_q;
  logic        entry_d, entry_q;
  logic        exit_d, exit_q;
  logic        dir_d, dir_q;
  logic        fault_d, fault_q;
  logic [31:0] tmo_d, tmo_q;
  logic        tmo_hit, far_rise, far_fall;

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign rise = deb_q & ~deb_dly_q;
  assign fall = ~deb_q & deb_dly_q;

  // The far sensor is the one opposite to the sensor that caused entry.
  assign far_rise = dir_q ? rise[0] : rise[1];
  assign far_fall = dir_q ? fall[0] : fall[1];
  assign tmo_hit  = (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    entry_d = 1'b0;
    exit_d  = 1'b0;
    dir_d   = dir_q;
    fault_d = fault_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        tmo_d = 32'd0;
        if (rise[0]) begin
          entry_d = 1'b1;
          dir_d   = 1'b0;
          state_d = OCC;
        end else if (rise[1]) begin
          entry_d = 1'b1;
          dir_d   = 1'b1;
          state_d = OCC;
        end
      end
      OCC: begin
        tmo_d = tmo_q + 32'd1;
        if (tmo_hit) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end else if (far_rise) begin
          state_d = LEAVE;
        end
      end
      LEAVE: begin
        tmo_d = tmo_q + 32'd1;
        // A clean departure outranks a coincident timeout.
        if (far_fall) begin
          exit_d  = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end
      end
      FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      deb_cnt_q <= '0;
      state_q   <= IDLE;
      entry_q   <= 1'b0;
      exit_q    <= 1'b0;
      dir_q     <= 1'b0;
      fault_q   <= 1'b0;
      tmo_q     <= 32'd0;
    end else begin
      sync1_q   <= {sens_b, sens_a};
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      entry_q   <= entry_d;
      exit_q    <= exit_d;
      dir_q     <= dir_d;
      fault_q   <= fault_d;
      tmo_q     <= tmo_d;
    end
  end

  assign entry = entry_q;
  assign exit  = exit_q;
  assign dir   = dir_q;
  assign busy  = (state_q != IDLE);
  assign fault = fault_q;

endmodule

// File: tb/tb_train_detector.sv
// tb/tb_train_detector.sv - directed checks for train_detector (DEB_CYCLES=4, TIMEOUT_CYCLES=100)
module tb_train_detector;

  logic clk = 1'b0;
  logic rst;
  logic sens_a;
  logic sens_b;
  logic entry;
  logic exit;
  logic dir;
  logic busy;
  logic fault;

  train_detector #(
    .DEB_CYCLES(16'd4),
    .TIMEOUT_CYCLES(32'd100)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .sens_a(sens_a),
    .sens_b(sens_b),
    .entry(entry),
    .exit(exit),
    .dir(dir),
    .busy(busy),
    .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_entry = 0;
  int   n_exit = 0;
  int   entry_cyc = -1;
  int   exit_cyc = -1;
  logic entry_dir = 1'b0;
  logic both_seen = 1'b0;
  logic deb_hi;
  int   n;
  int   r;
  int   saved;

  always @(negedge clk) begin
    if (entry && exit) both_seen = 1'b1;
    if (entry) begin
      n_entry++;
      entry_cyc = cyc;
      entry_dir = dir;
    end
    if (exit) begin
      n_exit++;
      exit_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic a, input logic b, output int t);
    @(posedge clk);
    #1;
    sens_a = a;
    sens_b = b;
    t = cyc;
  endtask

  task automatic to_cyc(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    sens_a = 1'b0;
    sens_b = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    sens_a = 1'b0;
    sens_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_entry", entry, 0);
    check("rst_exit", exit, 0);
    check("rst_dir", dir, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // A to B pass
    drive(1'b1, 1'b0, n);
    to_cyc(n + 20);
    check("ab_entry_cyc", entry_cyc, n + 7);
    check("ab_entry_dir", entry_dir, 0);
    check("ab_busy_occ", busy, 1);
    drive(1'b0, 1'b1, n);
    to_cyc(n + 20);
    check("ab_no_early_exit", n_exit, 0);
    drive(1'b0, 1'b0, n);
    to_cyc(n + 20);
    check("ab_exit_cyc", exit_cyc, n + 7);
    check("ab_entries", n_entry, 1);
    check("ab_exits", n_exit, 1);
    check("ab_busy_done", busy, 0);

    // bounce rejection: 2-cycle toggles never survive a 4-cycle debounce
    deb_hi = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      sens_a = ~sens_a;
      @(negedge clk);
      deb_hi = deb_hi | u_dut.deb_q[0];
      @(negedge clk);
      deb_hi = deb_hi | u_dut.deb_q[0];
    end
    drive(1'b0, 1'b0, n);
    to_cyc(n + 10);
    check("bnc_deb_a", deb_hi, 0);
    check("bnc_no_entry", n_entry, 1);
    drive(1'b1, 1'b0, n);
    to_cyc(n + 10);
    check("bnc_entry_cyc", entry_cyc, n + 7);
    check("bnc_entries", n_entry, 2);
    drive(1'b0, 1'b1, n);
    to_cyc(n + 12);
    drive(1'b0, 1'b0, n);
    to_cyc(n + 12);
    check("bnc_exits", n_exit, 2);
    check("bnc_busy_done", busy, 0);

    // B to A pass
    drive(1'b0, 1'b1, n);
    to_cyc(n + 20);
    check("ba_entry_cyc", entry_cyc, n + 7);
    check("ba_entry_dir", entry_dir, 1);
    drive(1'b1, 1'b0, n);
    to_cyc(n + 20);
    check("ba_no_early_exit", n_exit, 2);
    drive(1'b0, 1'b0, n);
    to_cyc(n + 20);
    check("ba_exit_cyc", exit_cyc, n + 7);
    check("ba_exits", n_exit, 3);
    check("ba_busy_done", busy, 0);
    check("ba_dir_held", dir, 1);

    // simultaneous rise: A wins
    drive(1'b1, 1'b1, n);
    to_cyc(n + 10);
    check("sim_entry_cyc", entry_cyc, n + 7);
    check("sim_dir", dir, 0);
    check("sim_entries", n_entry, 4);
    pulse_reset();

    // occupancy timeout
    drive(1'b1, 1'b0, n);
    to_cyc(n + 106);
    check("tmo_fault_pre", fault, 0);
    check("tmo_busy_pre", busy, 1);
    to_cyc(n + 107);
    check("tmo_fault", fault, 1);
    check("tmo_busy", busy, 1);
    check("tmo_entries", n_entry, 5);
    saved = n_exit;
    drive(1'b0, 1'b1, n);
    to_cyc(n + 15);
    drive(1'b0, 1'b0, n);
    to_cyc(n + 15);
    drive(1'b1, 1'b0, n);
    to_cyc(n + 15);
    drive(1'b0, 1'b0, n);
    to_cyc(n + 15);
    check("flt_no_entry", n_entry, 5);
    check("flt_no_exit", n_exit, saved);
    check("flt_sticky", fault, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("flt_rst_fault", fault, 0);
    check("flt_rst_busy", busy, 0);
    check("flt_rst_dir", dir, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("flt_post_fault", fault, 0);
    check("flt_post_busy", busy, 0);
    check("flt_post_entries", n_entry, 5);

    // reset while in LEAVE with B still high
    drive(1'b1, 1'b0, n);
    to_cyc(n + 12);
    drive(1'b0, 1'b1, n);
    to_cyc(n + 12);
    check("mr_busy_leave", busy, 1);
    saved = n_exit;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mr_rst_busy", busy, 0);
    check("mr_rst_exit", exit, 0);
    check("mr_rst_dir", dir, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    r = cyc;
    to_cyc(r + 10);
    check("mr_entry_cyc", entry_cyc, r + 7);
    check("mr_entry_dir", entry_dir, 1);
    check("mr_no_exit", n_exit, saved);

    check("no_overlap", both_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
